// File: rtl/tx_word_arbiter.sv
// tx_word_arbiter: round-robin arbiter sharing one byte-wide UART transmitter
// between two word requesters. The granted word is latched, then sent as
// N_BYTES bytes, each issued with a one-cycle tx_start pulse and paced by the
// transmitter's tx_done_tick.
module tx_word_arbiter #(
  parameter int N_DATA    = 8,
  parameter int N_WORD    = 32,
  parameter int MSB_FIRST = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic [N_WORD-1:0] word_a,
  output logic              ack_a,
  output logic              done_a,
  input  logic              req_b,
  input  logic [N_WORD-1:0] word_b,
  output logic              ack_b,
  output logic              done_b,
  output logic              busy,
  output logic              tx_start,
  output logic [N_DATA-1:0] tx_data,
  input  logic              tx_done_tick
);

  localparam int N_BYTES = N_WORD / N_DATA;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [N_WORD-1:0] shift_reg;
  logic [N_WORD-1:0] shift_nxt;
  logic [N_DATA-1:0] out_byte;
  logic [CNT_W-1:0]  byte_cnt;
  logic              owner;       // 0 = A, 1 = B
  logic              last_grant;  // 0 = A, 1 = B
  logic              grant;
  logic              grant_b;
  logic              last_byte;
  logic              byte_done;

  assign last_byte = (byte_cnt == LAST_CNT);
  // Only WAIT looks at tx_done_tick, so the level-high idle tick never counts.
  assign byte_done = (state == WAIT) && tx_done_tick;

  // Output byte always sits at one end of shift_reg; shifting moves the next one in.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign out_byte  = shift_reg[N_WORD-1 -: N_DATA];
      assign shift_nxt = shift_reg << N_DATA;
    end else begin : g_lsb
      assign out_byte  = shift_reg[N_DATA-1:0];
      assign shift_nxt = shift_reg >> N_DATA;
    end
  endgenerate

  // Next-state and grant decision; on a tie B wins only if A was granted last.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          grant   = 1'b1;
          grant_b = req_b && (!req_a || !last_grant);
          state_n = ISSUE;
        end
      end
      ISSUE:   state_n = WAIT;
      WAIT:    if (tx_done_tick) state_n = last_byte ? IDLE : ISSUE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Word latch, byte shifting and grant bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg  <= '0;
      byte_cnt   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant) begin
      shift_reg  <= grant_b ? word_b : word_a;
      byte_cnt   <= '0;
      owner      <= grant_b;
      last_grant <= grant_b;
    end else if (byte_done && !last_byte) begin
      shift_reg  <= shift_nxt;
      byte_cnt   <= byte_cnt + 1'b1;
    end
  end

  // Word-complete pulse lands in the first IDLE cycle after the last byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_a <= 1'b0;
      done_b <= 1'b0;
    end else begin
      done_a <= byte_done && last_byte && !owner;
      done_b <= byte_done && last_byte &&  owner;
    end
  end

  // ISSUE is exactly one cycle, so tx_start is a single pulse per byte;
  // ack rides on the first byte's pulse only.
  assign busy     = (state != IDLE);
  assign tx_start = (state == ISSUE);
  assign tx_data  = tx_start ? out_byte : '0;
  assign ack_a    = tx_start && (byte_cnt == '0) && !owner;
  assign ack_b    = tx_start && (byte_cnt == '0) &&  owner;

endmodule

// File: tb/tb_tx_word_arbiter.sv
// Testbench for tx_word_arbiter: two instances (LSB-first and MSB-first) run
// in lockstep on shared requesters and a behavioural UART, checked against a
// transaction-level model of arbitration and byte ordering.
module tb_tx_word_arbiter;
  localparam int NB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] word_a = '0, word_b = '0;
  logic        tx_done_tick;

  logic       ack_a0, done_a0, ack_b0, done_b0, busy0, tx_start0;
  logic [7:0] tx_data0;
  logic       ack_a1, done_a1, ack_b1, done_b1, busy1, tx_start1;
  logic [7:0] tx_data1;

  always #5 clock = ~clock;

  tx_word_arbiter #(.N_DATA(8), .N_WORD(32), .MSB_FIRST(0)) dut0 (
    .clock(clock), .reset(reset),
    .req_a(req_a), .word_a(word_a), .ack_a(ack_a0), .done_a(done_a0),
    .req_b(req_b), .word_b(word_b), .ack_b(ack_b0), .done_b(done_b0),
    .busy(busy0), .tx_start(tx_start0), .tx_data(tx_data0),
    .tx_done_tick(tx_done_tick));

  tx_word_arbiter #(.N_DATA(8), .N_WORD(32), .MSB_FIRST(1)) dut1 (
    .clock(clock), .reset(reset),
    .req_a(req_a), .word_a(word_a), .ack_a(ack_a1), .done_a(done_a1),
    .req_b(req_b), .word_b(word_b), .ack_b(ack_b1), .done_b(done_b1),
    .busy(busy1), .tx_start(tx_start1), .tx_data(tx_data1),
    .tx_done_tick(tx_done_tick));

  // UART model: frame of u_cnt+1 cycles after tx_start, done pulse in the last.
  logic u_busy;
  int   u_cnt;
  int   u_viol = 0;
  logic idle_high = 1'b1;
  bit   rand_len = 1'b0;
  int   frame_len = 20;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      u_busy <= 1'b0;
      u_cnt  <= 0;
    end else if (tx_start0) begin
      if (u_busy) u_viol <= u_viol + 1;
      else begin
        u_busy <= 1'b1;
        u_cnt  <= rand_len ? int'($urandom_range(2, 20)) : frame_len;
      end
    end else if (u_busy) begin
      if (u_cnt == 0) u_busy <= 1'b0;
      else            u_cnt  <= u_cnt - 1;
    end
  end
  assign tx_done_tick = u_busy ? (u_cnt == 0) : idle_high;

  // Check bookkeeping
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requesters: queued words, req held while anything is queued
  logic [31:0] qa[$], qb[$];

  // Reference model state (transaction level)
  int          pend, done_nxt, owner, idx, last_g;
  bit          issue_nxt, m_busy, in_wait;
  logic [31:0] pend_word, cur;

  int n_start0, n_start1, n_ack_a, n_ack_b, n_done_a, n_done_b, cyc;
  int s_start, s_aa, s_ab, s_da, s_db;
  int alog[$];
  bit phase4;
  int last_done_cyc;

  function automatic logic [31:0] byte_of(input logic [31:0] w, input int i, input bit msb);
    int s;
    s = msb ? 8 * (NB - 1 - i) : 8 * i;
    return (w >> s) & 32'hFF;
  endfunction

  task automatic model_reset();
    pend = 0; done_nxt = 0; owner = 0; idx = 0; last_g = 2;
    issue_nxt = 0; m_busy = 0; in_wait = 0; pend_word = '0; cur = '0;
  endtask

  // Drive requester inputs; if the arbiter is idle now, predict its grant.
  task automatic plan(input bit idle);
    req_a  = (qa.size() != 0);
    req_b  = (qb.size() != 0);
    word_a = req_a ? qa[0] : 32'h0;
    word_b = req_b ? qb[0] : 32'h0;
    if (idle) begin
      if (req_a && (!req_b || last_g == 2)) begin pend = 1; pend_word = word_a; end
      else if (req_b) begin pend = 2; pend_word = word_b; end
      if (pend != 0) last_g = pend;
    end
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_start0"}, {31'b0, tx_start0}, 0);
    chk({tag, "_data0"},  {24'b0, tx_data0}, 0);
    chk({tag, "_busy0"},  {31'b0, busy0}, 0);
    chk({tag, "_acks0"},  {30'b0, ack_a0, ack_b0}, 0);
    chk({tag, "_dones0"}, {30'b0, done_a0, done_b0}, 0);
    chk({tag, "_start1"}, {31'b0, tx_start1}, 0);
    chk({tag, "_data1"},  {24'b0, tx_data1}, 0);
    chk({tag, "_busy1"},  {31'b0, busy1}, 0);
    chk({tag, "_acks1"},  {30'b0, ack_a1, ack_b1}, 0);
    chk({tag, "_dones1"}, {30'b0, done_a1, done_b1}, 0);
  endtask

  // One clock: check this cycle's outputs, advance model, drive next inputs.
  task automatic step();
    bit ea, eb, es, eda, edb, idle_c;
    @(negedge clock);
    cyc++;
    ea = (pend == 1);
    eb = (pend == 2);
    es = (pend != 0) || issue_nxt;
    if (pend != 0) begin
      owner = pend; cur = pend_word; idx = 0; m_busy = 1;
    end
    eda = (done_nxt == 1);
    edb = (done_nxt == 2);
    chk("ack_a0", {31'b0, ack_a0}, {31'b0, ea});
    chk("ack_b0", {31'b0, ack_b0}, {31'b0, eb});
    chk("ack_a1", {31'b0, ack_a1}, {31'b0, ea});
    chk("ack_b1", {31'b0, ack_b1}, {31'b0, eb});
    chk("tx_start0", {31'b0, tx_start0}, {31'b0, es});
    chk("tx_start1", {31'b0, tx_start1}, {31'b0, es});
    if (es) begin
      chk("tx_data_lsb", {24'b0, tx_data0}, byte_of(cur, idx, 1'b0));
      chk("tx_data_msb", {24'b0, tx_data1}, byte_of(cur, idx, 1'b1));
    end
    chk("busy0", {31'b0, busy0}, {31'b0, m_busy});
    chk("busy1", {31'b0, busy1}, {31'b0, m_busy});
    chk("done_a0", {31'b0, done_a0}, {31'b0, eda});
    chk("done_b0", {31'b0, done_b0}, {31'b0, edb});
    chk("done_a1", {31'b0, done_a1}, {31'b0, eda});
    chk("done_b1", {31'b0, done_b1}, {31'b0, edb});

    n_start0 += int'(tx_start0);
    n_start1 += int'(tx_start1);
    n_ack_a  += int'(ack_a0);
    n_ack_b  += int'(ack_b0);
    n_done_a += int'(done_a0);
    n_done_b += int'(done_b0);
    if (ack_a0) alog.push_back(1);
    if (ack_b0) alog.push_back(2);
    if (phase4 && ack_a0 && last_done_cyc > 0)
      chk("done_to_ack", cyc - last_done_cyc, 1);
    if (done_a0) last_done_cyc = cyc;

    pend = 0; issue_nxt = 0; done_nxt = 0;
    idle_c = !m_busy;
    if (m_busy) begin
      if (es) in_wait = 1;
      else if (in_wait && tx_done_tick) begin
        in_wait = 0;
        idx++;
        if (idx == NB) begin done_nxt = owner; m_busy = 0; end
        else issue_nxt = 1;
      end
    end

    if (ack_a0 && qa.size() != 0) void'(qa.pop_front());
    if (ack_b0 && qb.size() != 0) void'(qb.pop_front());
    plan(idle_c);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || m_busy || pend != 0 || done_nxt != 0) && n < 4000) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, {31'b0, (n < 4000)}, 1);
    repeat (2) step();
  endtask

  task automatic snap();
    s_start = n_start0; s_aa = n_ack_a; s_ab = n_ack_b; s_da = n_done_a; s_db = n_done_b;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    quiet(tag);
    model_reset();
    reset = 1'b1;
    plan(1'b1);
  endtask

  initial begin
    model_reset();
    n_start0 = 0; n_start1 = 0; n_ack_a = 0; n_ack_b = 0; n_done_a = 0; n_done_b = 0;
    cyc = 0; phase4 = 0; last_done_cyc = 0;

    // 1: single LSB/MSB-first word from A, fixed 20-cycle frames
    frame_len = 20; rand_len = 0; idle_high = 1;
    qa.push_back(32'hDEADBEEF);
    do_reset("rst");
    snap();
    drain("p1");
    chk("p1_starts", n_start0 - s_start, 4);
    chk("p1_starts1", n_start1 - s_start, 4);
    chk("p1_ack_a", n_ack_a - s_aa, 1);
    chk("p1_done_a", n_done_a - s_da, 1);
    chk("p1_busy", {31'b0, busy0}, 0);

    // 2: single word from B; A side stays silent
    snap();
    qb.push_back(32'h12345678);
    drain("p2");
    chk("p2_starts", n_start0 - s_start, 4);
    chk("p2_ack_b", n_ack_b - s_ab, 1);
    chk("p2_done_b", n_done_b - s_db, 1);
    chk("p2_ack_a", n_ack_a - s_aa, 0);
    chk("p2_done_a", n_done_a - s_da, 0);

    // 3: both requesting from reset, 4 words each -> strict alternation
    rand_len = 1;
    for (int i = 0; i < 4; i++) begin
      qa.push_back($urandom);
      qb.push_back($urandom);
    end
    do_reset("rst3");
    alog.delete();
    snap();
    drain("p3");
    chk("p3_grants", alog.size(), 8);
    for (int i = 0; i < alog.size() && i < 8; i++)
      chk($sformatf("p3_order%0d", i), alog[i], (i % 2 == 0) ? 1 : 2);
    chk("p3_starts", n_start0 - s_start, 32);

    // 4: A alone holds req for three words; done -> next ack is one cycle
    snap();
    phase4 = 1; last_done_cyc = 0;
    qa.push_back(32'h1); qa.push_back(32'h2); qa.push_back(32'h3);
    drain("p4");
    phase4 = 0;
    chk("p4_starts", n_start0 - s_start, 12);
    chk("p4_ack_a", n_ack_a - s_aa, 3);
    chk("p4_done_a", n_done_a - s_da, 3);

    // 5: random traffic, with tx_done_tick low and then high while the UART idles
    for (int pass = 0; pass < 2; pass++) begin
      int nw;
      idle_high = (pass == 1);
      snap();
      nw = 0;
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 1) == 1) qa.push_back($urandom); else qb.push_back($urandom);
        nw++;
      end
      drain($sformatf("p5_%0d", pass));
      chk($sformatf("p5_%0d_starts", pass), n_start0 - s_start, 4 * nw);
      chk($sformatf("p5_%0d_dones", pass), (n_done_a - s_da) + (n_done_b - s_db), nw);
    end
    idle_high = 1;
    chk("uart_overlap", u_viol, 0);

    // 6: reset while waiting on the third byte, then a clean word
    qa.push_back($urandom);
    begin
      int n;
      n = 0;
      while (!(m_busy && in_wait && idx == 2) && n < 2000) begin step(); n++; end
      chk("p6_reached", {31'b0, (n < 2000)}, 1);
    end
    snap();
    #2 reset = 1'b0;
    #1 quiet("p6_async");
    qa.delete(); qb.delete();
    repeat (2) @(negedge clock);
    quiet("p6_hold");
    chk("p6_no_done", n_done_a - s_da, 0);
    qa.push_back(32'hCAFEF00D);
    model_reset();
    reset = 1'b1;
    plan(1'b1);
    snap();
    drain("p6");
    chk("p6_starts", n_start0 - s_start, 4);
    chk("p6_done_a", n_done_a - s_da, 1);
    chk("p6_uart_overlap", u_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
